// File: rtl/mealey_diff_decoder_if.sv
// Stream bus for the differential decoder: accumulated samples in, recovered increments out.
interface mealey_diff_decoder_if;
  logic              in_valid;
  logic signed [8:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic signed [8:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mealey_diff_decoder.sv
// Differential decoder: inverts a 9-bit wrapping accumulator (out = in - prev)
// and buffers results in a 2-entry FIFO with valid/ready on both sides.
module mealey_diff_decoder (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  input  logic                  clear,
  mealey_diff_decoder_if.slave  bus,
  output logic [15:0]           sample_cnt
);

  localparam int unsigned DW = 9;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_prev;
  logic [DW-1:0]   r_head;
  logic [DW-1:0]   r_tail;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   w_diff;
  logic            w_accept;
  logic            w_pop;
  logic            w_head_ld;
  logic            w_head_from_tail;
  logic            w_tail_ld;

  assign bus.in_ready  = (r_state != ST_FULL) && !clear;
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_data  = r_head;
  assign sample_cnt    = r_cnt;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_pop    = bus.out_valid && bus.out_ready && !clear;
  assign w_diff   = DW'(bus.in_data) - r_prev;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) r_state <= ST_EMPTY;
    else                  r_state <= w_state_nxt;
  end

  // Buffer occupancy and which data register loads; head is always the oldest entry.
  always_comb begin
    w_state_nxt      = r_state;
    w_head_ld        = 1'b0;
    w_head_from_tail = 1'b0;
    w_tail_ld        = 1'b0;
    if (clear) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_head_ld   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_head_ld = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_tail_ld   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt      = ST_ONE;
            w_head_from_tail = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_prev <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (clear) begin
        r_prev <= '0;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_prev <= DW'(bus.in_data);
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_head_ld)             r_head <= w_diff;
      else if (w_head_from_tail) r_head <= r_tail;
      if (w_tail_ld)             r_tail <= w_diff;
    end
  end

endmodule
